// File: rtl/countdown_timer.sv
// countdown_timer: loadable tick down-counter with one-shot/auto-reload expiry pulse.
module countdown_timer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          abort,
    input  logic          auto_reload,
    input  logic [DW-1:0] load_value,
    output logic [DW-1:0] count,
    output logic          busy,
    output logic          expired
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [DW-1:0] count_d, reload_q, reload_d;
    logic expired_d;
    always_comb begin
        state_d   = state_q;
        count_d   = count;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            // a zero load is a zero-length timer: expire at once, never enter RUN
            state_d   = (load_value != '0) ? RUN : IDLE;
            count_d   = load_value;
            reload_d  = (load_value != '0) ? load_value : reload_q;
            expired_d = (load_value == '0);
        end else if (state_q == RUN && en) begin
            if (count == DW'(1)) begin
                expired_d = 1'b1;
                state_d   = auto_reload ? RUN : IDLE;
                count_d   = auto_reload ? reload_q : '0;
            end else begin
                count_d = count - DW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count    <= '0;
            reload_q <= '0;
            expired  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            expired  <= expired_d;
        end
    end
    assign busy = (state_q == RUN);
endmodule
